// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi decoder self-test harness.
package viterbi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    localparam int N_SYM_DEFAULT = 2;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

    // Result counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/viterbi_bist_checker.sv
// Compares decoded bits against the reference ROM and keeps the run's
// correct/error counts plus the sticky overrun flag.
module viterbi_bist_checker
    import viterbi_pkg::*;
#(
    parameter int NUM_OUT = 32,
    localparam int REF_AW = cnt_w(NUM_OUT),
    localparam int OCW    = cnt_w(NUM_OUT + 1)
)(
    input  logic              clk,
    input  logic              RSTn,
    input  logic              clear,
    input  logic              enable,
    input  logic              d_out_valid,
    input  logic              d_out,
    input  logic              ref_data,
    output logic [REF_AW-1:0] ref_addr,
    output logic [31:0]       correct_cnt,
    output logic [31:0]       error_cnt,
    output logic              overrun,
    output logic              out_full
);

    logic [OCW-1:0] out_cnt_reg, out_cnt_next;
    logic [31:0]    correct_cnt_reg, correct_cnt_next;
    logic [31:0]    error_cnt_reg, error_cnt_next;
    logic           overrun_reg, overrun_next;

    assign out_full = (out_cnt_reg == OCW'(NUM_OUT));

    always_comb begin
        out_cnt_next     = out_cnt_reg;
        correct_cnt_next = correct_cnt_reg;
        error_cnt_next   = error_cnt_reg;
        overrun_next     = overrun_reg;
        if (clear) begin
            out_cnt_next     = '0;
            correct_cnt_next = '0;
            error_cnt_next   = '0;
            overrun_next     = 1'b0;
        end else if (enable && d_out_valid) begin
            if (!out_full) begin
                if (d_out == ref_data) begin
                    correct_cnt_next = sat_inc32(correct_cnt_reg);
                end else begin
                    error_cnt_next = sat_inc32(error_cnt_reg);
                end
                out_cnt_next = out_cnt_reg + OCW'(1);
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            out_cnt_reg     <= '0;
            correct_cnt_reg <= '0;
            error_cnt_reg   <= '0;
            overrun_reg     <= 1'b0;
        end else begin
            out_cnt_reg     <= out_cnt_next;
            correct_cnt_reg <= correct_cnt_next;
            error_cnt_reg   <= error_cnt_next;
            overrun_reg     <= overrun_next;
        end
    end

    // The reference ROM is always addressed by the next bit to be checked.
    assign ref_addr    = out_cnt_reg[REF_AW-1:0];
    assign correct_cnt = correct_cnt_reg;
    assign error_cnt   = error_cnt_reg;
    assign overrun     = overrun_reg;

endmodule

// File: rtl/viterbi_bist.sv
// Self-test harness for viterbi_decoder: streams symbols from a ROM, optionally
// with idle gaps, and checks decoded bits against a reference ROM.
module viterbi_bist
    import viterbi_pkg::*;
#(
    parameter int N_SYM      = N_SYM_DEFAULT,
    parameter int NUM_STEPS  = 64,
    parameter int NUM_OUT    = 32,
    parameter int GAP_PERIOD = 4,
    parameter int TIMEOUT    = 1024,
    localparam int SYM_AW    = cnt_w(NUM_STEPS),
    localparam int REF_AW    = cnt_w(NUM_OUT)
)(
    input  logic              clk,
    input  logic              RSTn,
    input  logic              start,
    input  logic              gap_en,
    output logic [SYM_AW-1:0] sym_addr,
    input  logic [N_SYM-1:0]  sym_data,
    output logic [REF_AW-1:0] ref_addr,
    input  logic              ref_data,
    output logic              d_in_valid,
    output logic [N_SYM-1:0]  d_in,
    input  logic              d_out_valid,
    input  logic              d_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overrun,
    output logic [31:0]       correct_cnt,
    output logic [31:0]       error_cnt
);

    localparam int GAP_W = cnt_w(GAP_PERIOD);
    localparam int TO_W  = cnt_w(TIMEOUT + 1);

    bist_state_t       state_reg, state_next;
    logic [SYM_AW-1:0] sym_addr_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              gap_en_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              timeout_reg;
    logic              d_in_valid_reg;

    logic start_ok;
    logic issue;
    logic last_issue;
    logic out_full;
    logic gap_now;
    logic to_expire;

    assign gap_now   = gap_en_reg && (gap_cnt_reg == GAP_W'(GAP_PERIOD - 1));
    assign to_expire = (to_cnt_reg == TO_W'(TIMEOUT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_DRIVE;
            ST_DRIVE: if (last_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (out_full || to_expire) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_DRIVE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        start_ok   = 1'b0;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                start_ok = start;
            end
            ST_DRIVE: begin
                busy       = 1'b1;
                issue      = !gap_now;
                last_issue = !gap_now && (sym_addr_reg == SYM_AW'(NUM_STEPS - 1));
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done     = 1'b1;
                start_ok = start;
            end
            default: ;
        endcase
    end

    // Driver: address counter, gap phase and DRAIN watchdog.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sym_addr_reg   <= '0;
            gap_cnt_reg    <= '0;
            gap_en_reg     <= 1'b0;
            to_cnt_reg     <= '0;
            timeout_reg    <= 1'b0;
            d_in_valid_reg <= 1'b0;
        end else begin
            d_in_valid_reg <= issue;
            if (start_ok) begin
                sym_addr_reg <= '0;
                gap_cnt_reg  <= '0;
                gap_en_reg   <= gap_en;
                to_cnt_reg   <= '0;
                timeout_reg  <= 1'b0;
            end else begin
                if (state_reg == ST_DRIVE) begin
                    gap_cnt_reg <= (gap_cnt_reg == GAP_W'(GAP_PERIOD - 1)) ? '0
                                                                           : gap_cnt_reg + GAP_W'(1);
                    if (issue && !last_issue) begin
                        sym_addr_reg <= sym_addr_reg + SYM_AW'(1);
                    end
                end
                if (state_reg == ST_DRAIN) begin
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    if (!out_full && to_expire) begin
                        timeout_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // The ROM word arrives one cycle after its address, aligned with the
    // registered valid; gating keeps d_in at zero whenever nothing is issued.
    for (genvar gi = 0; gi < N_SYM; gi++) begin : g_din
        assign d_in[gi] = sym_data[gi] & d_in_valid_reg;
    end

    viterbi_bist_checker #(
        .NUM_OUT (NUM_OUT)
    ) u_checker (
        .clk         (clk),
        .RSTn        (RSTn),
        .clear       (start_ok),
        .enable      (busy),
        .d_out_valid (d_out_valid),
        .d_out       (d_out),
        .ref_data    (ref_data),
        .ref_addr    (ref_addr),
        .correct_cnt (correct_cnt),
        .error_cnt   (error_cnt),
        .overrun     (overrun),
        .out_full    (out_full)
    );

    assign sym_addr   = sym_addr_reg;
    assign d_in_valid = d_in_valid_reg;
    assign timeout    = timeout_reg;
    assign pass       = done && (error_cnt == 32'd0) && !timeout_reg && !overrun;

endmodule
